// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu - registered, multi-cycle ALU with a persistent NZCV flag register.
//
// Single-cycle ops (logic, add/sub with carry chaining, barrel shifts) finish
// at the edge that samples start. MUL is an iterative shift-and-add that runs
// WIDTH steps after the capture edge. done pulses for one cycle after every
// completion, and OUT holds its value until the next completion.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset (highest priority)
//   start      in   issue request, sampled only while busy=0
//   control    in   4-bit opcode, sampled with start
//   set_flags  in   completing op updates NZCV when 1, sampled with start
//   DATA_A     in   operand A
//   DATA_B     in   operand B / shift amount (low SHW bits)
//   OUT        out  registered result
//   busy       out  high while a multiply is in progress
//   done       out  one-cycle completion pulse
//   N Z C V    out  registered flags
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] DATA_A,
    input  logic [WIDTH-1:0] DATA_B,
    output logic [WIDTH-1:0] OUT,
    output logic             busy,
    output logic             done,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V
);

    typedef enum logic {IDLE, MUL} state_t;

    localparam logic [3:0] OP_SUB = 4'b0010, OP_RSB = 4'b0011, OP_ADD = 4'b0100,
                           OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_RSC = 4'b0111,
                           OP_MUL = 4'b1000, OP_LSL = 4'b1001, OP_LSR = 4'b1010,
                           OP_ASR = 4'b1011, OP_AND = 4'b0000, OP_EOR = 4'b0001,
                           OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_BIC = 4'b1110,
                           OP_MVN = 4'b1111;

    state_t           state_q;
    logic [WIDTH-1:0] out_q, mcand_q, mplier_q, acc_q;
    logic [SHW-1:0]   cnt_q;
    logic             n_q, z_q, c_q, v_q, done_q, sf_q;

    // Single-cycle datapath
    logic [WIDTH-1:0] op_x, op_y, res_d, acc_d;
    logic             cin, is_arith, c_d, v_d;
    logic [WIDTH:0]   sum, lsl_w, lsr_w, asr_w;
    logic [SHW-1:0]   shamt;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statements can leave a value held (no latches).
        op_x     = DATA_A;
        op_y     = DATA_B;
        cin      = 1'b0;
        is_arith = 1'b1;
        // Subtraction is x + ~y + carry_in, so the carry out is NOT borrow.
        unique case (control)
            OP_SUB:  begin op_y = ~DATA_B; cin = 1'b1; end
            OP_RSB:  begin op_x = DATA_B; op_y = ~DATA_A; cin = 1'b1; end
            OP_ADD:  ;
            OP_ADC:  cin = c_q;
            OP_SBC:  begin op_y = ~DATA_B; cin = c_q; end
            OP_RSC:  begin op_x = DATA_B; op_y = ~DATA_A; cin = c_q; end
            default: is_arith = 1'b0;
        endcase

        sum   = {1'b0, op_x} + {1'b0, op_y} + (WIDTH+1)'(cin);
        shamt = DATA_B[SHW-1:0];
        // The extra bit on each shift catches the last bit shifted out.
        lsl_w = {1'b0, DATA_A} << shamt;
        lsr_w = {DATA_A, 1'b0} >> shamt;
        asr_w = $signed({DATA_A, 1'b0}) >>> shamt;

        res_d = '0;
        c_d   = c_q;
        v_d   = v_q;
        if (is_arith) begin
            res_d = sum[WIDTH-1:0];
            c_d   = sum[WIDTH];
            v_d   = (op_x[WIDTH-1] == op_y[WIDTH-1]) && (sum[WIDTH-1] != op_x[WIDTH-1]);
        end else begin
            unique case (control)
                OP_AND:  res_d = DATA_A & DATA_B;
                OP_EOR:  res_d = DATA_A ^ DATA_B;
                OP_ORR:  res_d = DATA_A | DATA_B;
                OP_MOV:  res_d = DATA_B;
                OP_BIC:  res_d = DATA_A & ~DATA_B;
                OP_MVN:  res_d = ~DATA_B;
                OP_LSL:  begin
                    res_d = lsl_w[WIDTH-1:0];
                    if (shamt != '0) c_d = lsl_w[WIDTH];
                end
                OP_LSR:  begin
                    res_d = lsr_w[WIDTH:1];
                    if (shamt != '0) c_d = lsr_w[0];
                end
                OP_ASR:  begin
                    res_d = asr_w[WIDTH:1];
                    if (shamt != '0) c_d = asr_w[0];
                end
                default: res_d = '0;   // MUL result comes from the iterator
            endcase
        end
    end

    // One shift-and-add step: add the multiplicand when the current LSB of
    // the multiplier is set.
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            out_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
            sf_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register sees the
            // pre-edge value of every other register regardless of order.
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (control == OP_MUL) begin
                            mcand_q  <= DATA_A;
                            mplier_q <= DATA_B;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            sf_q     <= set_flags;
                            state_q  <= MUL;
                        end else begin
                            out_q  <= res_d;
                            done_q <= 1'b1;
                            if (set_flags) begin
                                n_q <= res_d[WIDTH-1];
                                z_q <= (res_d == '0);
                                c_q <= c_d;
                                v_q <= v_d;
                            end
                        end
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == SHW'(WIDTH - 1)) begin
                        out_q   <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                        if (sf_q) begin
                            n_q <= acc_d[WIDTH-1];
                            z_q <= (acc_d == '0);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign OUT  = out_q;
    assign busy = (state_q == MUL);
    assign done = done_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign C    = c_q;
    assign V    = v_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Registered, multi-cycle successor to the combinational datapath ALU.
- Generalised to any power-of-two WIDTH, with a persistent NZCV flag register, internal carry chaining, conditional flag update, barrel shifts and an iterative shift-and-add multiply.
- A start/busy/done handshake lets the controller issue operations and wait on multi-cycle ones.
- Sits between the register file read ports and the writeback mux in the multi-cycle datapath.

Parameters:
- WIDTH, 8, datapath width in bits; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue request; sampled only when busy=0.
- control  input  4  operation code, sampled with start.
- set_flags  input  1  when 1, the completing operation updates NZCV; sampled with start.
- DATA_A  input  WIDTH  operand A, sampled with start.
- DATA_B  input  WIDTH  operand B / shift amount, sampled with start.
- OUT  output  WIDTH  registered result; holds its value until the next completion.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse; OUT is valid for the just-finished operation.
- N, Z, C, V  output  1 each  registered flag register.

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset: OUT=0, N=Z=C=V=0, busy=0, done=0, state=IDLE, multiply counter and accumulator cleared. Reset has priority over everything else.
- Reset mid-multiply aborts the operation: no done pulse, OUT and flags are cleared.
- States:
  - IDLE: start=1 with a single-cycle op writes OUT (and flags if set_flags) at that edge, and done=1 for the following cycle. start=1 with MUL latches operands and goes to MUL.
  - MUL: busy=1. One shift-and-add step per edge, WIDTH steps in total. At the WIDTH-th edge after the capture edge, OUT and flags are written, the state returns to IDLE, and done=1 for the next cycle.
- Back-to-back: start may be asserted in the same cycle that done is high.
- start while busy=1 is ignored and has no effect.
- done is high for exactly one cycle per accepted operation.
- Carry in for ADC/SBC/RSC is the registered C flag.
- Opcodes:
  - 0000 AND: A&B.
  - 0001 EOR: A^B.
  - 0010 SUB: A-B.
  - 0011 RSB: B-A.
  - 0100 ADD: A+B.
  - 0101 ADC: A+B+C.
  - 0110 SBC: A-B-~C.
  - 0111 RSC: B-A-~C.
  - 1000 MUL: low WIDTH bits of A*B (unsigned).
  - 1001 LSL: A shifted left by B[SHW-1:0].
  - 1010 LSR: A shifted right by B[SHW-1:0], zero fill.
  - 1011 ASR: A shifted right by B[SHW-1:0], sign fill.
  - 1100 ORR: A|B.
  - 1101 MOV: B.
  - 1110 BIC: A&~B.
  - 1111 MVN: ~B.
- Flag update applies only when set_flags=1; otherwise all four flags hold.
  - N=OUT[WIDTH-1]; Z=(OUT==0).
  - Add ops: C = carry out of bit WIDTH-1. V = operands have the same sign and the result sign differs.
  - Sub ops: C = NOT borrow (1 when no unsigned borrow, e.g. A>=B for SUB). V = operand signs differ and the result sign differs from the minuend.
  - Shifts, amount k>0: LSL C=A[WIDTH-k]; LSR/ASR C=A[k-1]. For k=0, C holds. V holds.
  - Logical ops, MOV, MVN, MUL: update N and Z only; C and V hold.
- All arithmetic is computed in WIDTH+1 bits internally; OUT is truncated to WIDTH bits.

Test Plan (WIDTH=8):
- ADD A=7F B=01 S=1 -> OUT=80, N=1 Z=0 C=0 V=1; done high exactly one cycle after the capture edge; busy stays 0.
- ADD FF+01 S=1 -> OUT=00 Z=1 C=1; then ADC 00+00 -> OUT=01. Then SUB 05-05 S=1 -> OUT=00 Z=1 C=1 V=0. Then SUB 03-05 S=1 -> OUT=FE N=1 C=0.
- MUL 0D*0B S=1 -> busy high 8 cycles, done after the 8th edge, OUT=8F N=1, C/V unchanged. A start pulse (ADD) at busy cycle 4 is ignored: OUT stays 8F and only one done pulse occurs.
- ASR 81 by 1 S=1 -> OUT=C0 C=1 N=1. LSL 81 by 0 -> OUT=81, C unchanged. LSR 81 by 7 -> OUT=01 C=0.
- set_flags=0 on SUB 00-01 -> OUT=FF, NZCV identical to the prior values.
- reset asserted at MUL step 3 -> next cycle busy=0, OUT=00, NZCV=0000, and no done pulse occurs afterwards.
